// File: rtl/byte_serial_adder_ctrl.sv
// Byte-serial W-bit add/subtract built around one shared 8-bit Kogge-Stone adder.
// Operands are latched on start and processed LSB byte first, one byte per clock.

module eight_bit_kogge_stone_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout,
  output logic       overflowFlag
);
  logic [7:0] p0_s, g0_s, p1_s, g1_s, p2_s, g2_s, g3_s;
  logic [7:0] c_s;

  assign p0_s = a ^ b;
  // Carry-in is folded into bit 0 so the prefix tree yields carries directly.
  assign g0_s = {a[7:1] & b[7:1], (a[0] & b[0]) | (p0_s[0] & cin)};

  assign g1_s = g0_s | (p0_s & {g0_s[6:0], 1'b0});
  assign p1_s = p0_s & {p0_s[6:0], 1'b0};
  assign g2_s = g1_s | (p1_s & {g1_s[5:0], 2'b00});
  assign p2_s = p1_s & {p1_s[5:0], 2'b00};
  assign g3_s = g2_s | (p2_s & {g2_s[3:0], 4'b0000});

  assign c_s          = {g3_s[6:0], cin};
  assign s            = p0_s ^ c_s;
  assign cout         = g3_s[7];
  assign overflowFlag = g3_s[7] ^ c_s[7];
endmodule

module byte_serial_adder_ctrl #(
  parameter int NUM_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   sub,
  input  logic                   Cin,
  input  logic [8*NUM_BYTES-1:0] A,
  input  logic [8*NUM_BYTES-1:0] B,
  output logic                   busy,
  output logic                   done,
  output logic [8*NUM_BYTES-1:0] S,
  output logic                   Cout,
  output logic                   overflowFlag
);
  localparam int W  = 8 * NUM_BYTES;
  localparam int CW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t        state_r, state_next_s;
  logic [CW-1:0] cnt_r;
  logic          carry_r;
  logic [W-1:0]  a_r, b_r, s_r;
  logic          cout_r, ovf_r, busy_r, done_r;
  logic [7:0]    add_s_s;
  logic          add_cout_s, add_ovf_s;
  logic          last_s;

  assign last_s = (cnt_r == LAST_IDX);

  eight_bit_kogge_stone_adder u_adder (
    .a            (a_r[{cnt_r, 3'b000} +: 8]),
    .b            (b_r[{cnt_r, 3'b000} +: 8]),
    .cin          (carry_r),
    .s            (add_s_s),
    .cout         (add_cout_s),
    .overflowFlag (add_ovf_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Operand latching, per-byte result write-back and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r   <= '0;
      carry_r <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      s_r     <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      busy_r <= (state_next_s != IDLE);
      done_r <= (state_next_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r     <= A;
            b_r     <= B ^ {W{sub}};
            carry_r <= sub ? 1'b1 : Cin;
            cnt_r   <= '0;
          end
        end
        RUN: begin
          s_r[{cnt_r, 3'b000} +: 8] <= add_s_s;
          carry_r <= add_cout_s;
          if (last_s) begin
            cout_r <= add_cout_s;
            ovf_r  <= add_ovf_s;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DONE: begin
          cnt_r <= '0;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign S            = s_r;
  assign Cout         = cout_r;
  assign overflowFlag = ovf_r;
endmodule

// File: tb/tb_byte_serial_adder_ctrl.sv
// Directed bench for byte_serial_adder_ctrl with hand-computed expected results.
module tb_byte_serial_adder_ctrl;
  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sub;
  logic        Cin;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] S;
  logic        Cout;
  logic        overflowFlag;

  int vectors = 0;
  int errors  = 0;
  int n;
  int busy_cnt;

  byte_serial_adder_ctrl #(.NUM_BYTES(NB)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .sub          (sub),
    .Cin          (Cin),
    .A            (A),
    .B            (B),
    .busy         (busy),
    .done         (done),
    .S            (S),
    .Cout         (Cout),
    .overflowFlag (overflowFlag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one operation at a negedge and check latency, busy span and result.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s_in, input logic c_in, input logic [31:0] exp_s,
                        input logic exp_c, input logic exp_v);
    @(negedge clk);
    A = a; B = b; sub = s_in; Cin = c_in; start = 1'b1;
    n = 0;
    busy_cnt = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (busy) busy_cnt++;
    end while (!done && n < 20);
    check({tag, "_latency"}, n, NB + 1);
    check({tag, "_busy"}, busy_cnt, NB + 1);
    check({tag, "_S"}, S, exp_s);
    check({tag, "_cout"}, {31'd0, Cout}, {31'd0, exp_c});
    check({tag, "_ovf"}, {31'd0, overflowFlag}, {31'd0, exp_v});
    @(negedge clk);
    check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    check({tag, "_done_end"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sub = 1'b0; Cin = 1'b0; A = 32'd0; B = 32'd0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_S", S, 32'd0);
    check("rst_flags", {30'd0, Cout, overflowFlag}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_op("cin_only", 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
    run_op("ripple",   32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    run_op("wrap",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op("ovf_pos",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("ovf_neg",  32'h96CA_2700, 32'hCA9B_9600, 1'b0, 1'b1, 32'h6165_BD01, 1'b1, 1'b1);
    run_op("sub_neg",  32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Handshake: operands change after acceptance, start pulsed in RUN and DONE.
    @(negedge clk);
    A = 32'h1111_1111; B = 32'h2222_2222; sub = 1'b0; Cin = 1'b0; start = 1'b1;
    @(negedge clk);
    n = 1;
    start = 1'b0; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; sub = 1'b1;
    @(negedge clk);
    n++;
    start = 1'b1;
    @(negedge clk);
    n++;
    start = 1'b0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("hs_latency", n, NB + 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("hs_done_single", {31'd0, done}, 32'd0);
    check("hs_busy_after", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("hs_not_queued", {31'd0, busy}, 32'd0);
    check("hs_S", S, 32'h3333_3333);
    check("hs_flags", {30'd0, Cout, overflowFlag}, 32'd0);

    // Reset while the counter sits at byte 2.
    @(negedge clk);
    A = 32'h0101_0101; B = 32'h0202_0202; sub = 1'b0; Cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_done", {31'd0, done}, 32'd0);
    check("mid_S", S, 32'd0);
    check("mid_flags", {30'd0, Cout, overflowFlag}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("post_rst", 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
